// File: rtl/mem_ctrl_pkg.sv
// Shared types for the data-memory controller: CPU memory-op encoding,
// controller states and small op-classification helpers.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        LW  = 3'd0,
        LH  = 3'd1,
        LHU = 3'd2,
        LB  = 3'd3,
        LBU = 3'd4,
        SW  = 3'd5,
        SH  = 3'd6,
        SB  = 3'd7
    } mem_op_t;

    typedef enum logic [1:0] {
        S_IDLE,     // accept a CPU or loader request
        S_RD_WAIT,  // CPU load data returning from memory
        S_MERGE,    // sub-word store: write back the merged word
        S_LD_RD     // loader read data returning from memory
    } ctrl_state_t;

    function automatic logic is_load(mem_op_t op);
        return op inside {LW, LH, LHU, LB, LBU};
    endfunction

    function automatic logic is_store(mem_op_t op);
        return op inside {SW, SH, SB};
    endfunction

    // Word ops need a 4-byte boundary, halfword ops a 2-byte boundary.
    function automatic logic is_misaligned(mem_op_t op, logic [1:0] off);
        case (op)
            LW, SW:      return off != 2'd0;
            LH, LHU, SH: return off[0];
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// Little-endian byte-lane steering: extracts a sign/zero-extended load
// result from a memory word and merges sub-word store data into a word.
module byte_lane_unit
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  mem_op_t     op,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Select the addressed byte/halfword and extend it to a load result.
    always_comb begin
        // NOTE: every variable gets a value on every path; a missing default in always_comb infers a latch.
        sel_byte  = word[7:0];
        sel_half  = off[1] ? word[31:16] : word[15:0];
        load_data = word;
        case (off)
            2'd1:    sel_byte = word[15:8];
            2'd2:    sel_byte = word[23:16];
            2'd3:    sel_byte = word[31:24];
            default: sel_byte = word[7:0];
        endcase
        case (op)
            LB:      load_data = {{24{sel_byte[7]}}, sel_byte};
            LBU:     load_data = {24'd0, sel_byte};
            LH:      load_data = {{16{sel_half[15]}}, sel_half};
            LHU:     load_data = {16'd0, sel_half};
            default: load_data = word;
        endcase
    end

    // Replace the addressed lane(s) of the old word with the store data.
    always_comb begin
        store_word = word;
        case (op)
            SB: begin
                case (off)
                    2'd0: store_word[7:0]   = wdata[7:0];
                    2'd1: store_word[15:8]  = wdata[7:0];
                    2'd2: store_word[23:16] = wdata[7:0];
                    2'd3: store_word[31:24] = wdata[7:0];
                    default: store_word     = word;
                endcase
            end
            SH: begin
                if (off[1]) store_word[31:16] = wdata[15:0];
                else        store_word[15:0]  = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Memory-stage controller for a word-wide single-port data memory with a
// one-cycle registered read. Serves CPU loads/stores (read-modify-write for
// sub-word stores) and shares the memory with a word-only loader port that
// is forced through after LD_STARVE_LIMIT consecutive CPU wins.
module data_mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W          = 10,
    parameter int LD_STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  mem_op_t           cpu_op,
    input  logic [ADDR_W+1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic              cpu_busy,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [31:0]       ld_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    localparam int               CNT_W   = $clog2(LD_STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LD_STARVE_LIMIT);

    ctrl_state_t       state_q, state_d;
    logic [CNT_W-1:0]  starve_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              force_ld, cpu_accept;
    logic              done_c, err_c, gnt_c, rvalid_c, we_c;
    logic [31:0]       rdata_c, ld_rdata_c;
    logic [31:0]       load_data, store_word;

    assign force_ld = (starve_cnt == CNT_MAX);

    // op/addr/wdata are held by the CPU until cpu_done, so the lane unit
    // can look at them directly in RD_WAIT and MERGE.
    byte_lane_unit u_lane (
        .word       (mem_dout),
        .op         (cpu_op),
        .off        (cpu_addr[1:0]),
        .wdata      (cpu_wdata),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Arbitration, next state and memory command for the current cycle.
    always_comb begin
        state_d    = state_q;
        cpu_accept = 1'b0;
        done_c     = 1'b0;
        err_c      = 1'b0;
        gnt_c      = 1'b0;
        rvalid_c   = 1'b0;
        we_c       = 1'b0;
        rdata_c    = '0;
        ld_rdata_c = '0;
        mem_din    = '0;
        mem_addr   = addr_q;
        unique case (state_q)
            S_IDLE: begin
                mem_addr = cpu_addr[ADDR_W+1:2];
                if (cpu_req && !force_ld) begin
                    cpu_accept = 1'b1;
                    if (is_misaligned(cpu_op, cpu_addr[1:0])) begin
                        done_c = 1'b1;
                        err_c  = 1'b1;
                    end else if (is_load(cpu_op)) begin
                        state_d = S_RD_WAIT;
                    end else if (cpu_op == SW) begin
                        we_c    = 1'b1;
                        mem_din = cpu_wdata;
                        done_c  = 1'b1;
                    end else begin
                        state_d = S_MERGE;
                    end
                end else if (ld_req) begin
                    mem_addr = ld_addr;
                    gnt_c    = 1'b1;
                    if (ld_we) begin
                        we_c    = 1'b1;
                        mem_din = ld_wdata;
                    end else begin
                        state_d = S_LD_RD;
                    end
                end
            end
            S_RD_WAIT: begin
                done_c  = 1'b1;
                rdata_c = load_data;
                state_d = S_IDLE;
            end
            S_MERGE: begin
                we_c    = 1'b1;
                mem_din = store_word;
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            S_LD_RD: begin
                rvalid_c   = 1'b1;
                ld_rdata_c = mem_dout;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Responses and write enable are held quiet in every reset cycle, so a
    // MERGE interrupted by reset never writes.
    assign cpu_done  = rst_n & done_c;
    assign cpu_err   = rst_n & err_c;
    assign ld_gnt    = rst_n & gnt_c;
    assign ld_rvalid = rst_n & rvalid_c;
    assign mem_we    = rst_n & we_c;
    assign cpu_rdata = rst_n ? rdata_c : '0;
    assign ld_rdata  = rst_n ? ld_rdata_c : '0;
    assign cpu_busy  = cpu_req & ~cpu_done;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values regardless of block evaluation order.
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Count CPU wins while the loader waits; saturation is implicit because
    // force_ld blocks further CPU accepts.
    always_ff @(posedge clk) begin
        if (!rst_n)                 starve_cnt <= '0;
        else if (!ld_req || gnt_c)  starve_cnt <= '0;
        else if (cpu_accept)        starve_cnt <= starve_cnt + CNT_W'(1);
    end

    // Capture the word address issued in IDLE for the follow-up state.
    always_ff @(posedge clk) begin
        // NOTE: datapath register with no reset; it is only read in states entered right after it is loaded.
        if (state_q == S_IDLE) addr_q <= mem_addr;
    end

endmodule
